// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared codes, FSM state enum and default widths for arith_cmd_issuer
// Ports: none (package).

package arith_pkg;

  localparam int IN_DATA_WD_DEF  = 16;
  localparam int OUT_WD_DEF      = 2 * IN_DATA_WD_DEF;
  localparam int TIMEOUT_CYC_DEF = 15;

  typedef enum logic [1:0] {
    FUN_ADD = 2'b00,
    FUN_SUB = 2'b01,
    FUN_MUL = 2'b10,
    FUN_DIV = 2'b11
  } fun_e;

  typedef enum logic [1:0] {
    ERR_OK      = 2'b00,
    ERR_DIV0    = 2'b01,
    ERR_TIMEOUT = 2'b10
  } err_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/arith_cmd_issuer_if.sv
// rtl/arith_cmd_issuer_if.sv - command, arithmetic-unit and response signals of arith_cmd_issuer
// Signals: cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_fun (command), arith_a/arith_b/arith_fun/
//          arith_en/arith_out/arith_flag (arithmetic unit), rsp_valid/rsp_ready/rsp_data/
//          rsp_err (response), busy.
// Modports: master = issuer side, slave = front end plus arithmetic unit side.

interface arith_cmd_issuer_if
  import arith_pkg::*;
#(
  parameter int IN_DATA_WD = IN_DATA_WD_DEF,
  parameter int OUT_WD     = 2 * IN_DATA_WD
) ();

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [IN_DATA_WD-1:0] cmd_a;
  logic [IN_DATA_WD-1:0] cmd_b;
  logic [1:0]            cmd_fun;

  logic [IN_DATA_WD-1:0] arith_a;
  logic [IN_DATA_WD-1:0] arith_b;
  logic [1:0]            arith_fun;
  logic                  arith_en;
  logic [OUT_WD-1:0]     arith_out;
  logic                  arith_flag;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [OUT_WD-1:0]     rsp_data;
  logic [1:0]            rsp_err;

  logic                  busy;

  modport master (
    input  cmd_valid, cmd_a, cmd_b, cmd_fun, arith_out, arith_flag, rsp_ready,
    output cmd_ready, arith_a, arith_b, arith_fun, arith_en, rsp_valid, rsp_data, rsp_err, busy
  );

  modport slave (
    output cmd_valid, cmd_a, cmd_b, cmd_fun, arith_out, arith_flag, rsp_ready,
    input  cmd_ready, arith_a, arith_b, arith_fun, arith_en, rsp_valid, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/arith_cmd_issuer.sv
// rtl/arith_cmd_issuer.sv - issues one arithmetic op at a time and returns its result
// Ports: clk (rising edge), rst (synchronous, active-high), bus (arith_cmd_issuer_if.master:
//        command in, operand/function/enable out to the unit, result in, response out, busy).
// Optional macro ARITH_ISSUER_TIMEOUT_EN: bounds WAIT to TIMEOUT_CYC flagless cycles.

module arith_cmd_issuer
  import arith_pkg::*;
#(
  parameter int IN_DATA_WD  = IN_DATA_WD_DEF,
  parameter int OUT_WD      = 2 * IN_DATA_WD
`ifdef ARITH_ISSUER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
  input  logic                clk,
  input  logic                rst,
  arith_cmd_issuer_if.master  bus
);

  state_e                state_q;
  state_e                state_d;

  logic [IN_DATA_WD-1:0] arith_a_q;
  logic [IN_DATA_WD-1:0] arith_b_q;
  logic [1:0]            arith_fun_q;
  logic [OUT_WD-1:0]     rsp_data_q;
  logic [1:0]            rsp_err_q;

  logic                  accept;
  logic                  div0;
  logic                  timeout_hit;

  logic                  arith_en;
  logic                  rsp_valid;
  logic                  busy;
  logic                  cmd_ready;

  // Reset has priority in every register, so accept need not re-check rst.
  assign accept = (state_q == ST_IDLE) && bus.cmd_valid;
  assign div0   = (bus.cmd_fun == FUN_DIV) && (bus.cmd_b == '0);

`ifdef ARITH_ISSUER_TIMEOUT_EN
  localparam int CNT_WD = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_WD-1:0] wait_cnt_q;

  // Fires on the TIMEOUT_CYC-th flagless WAIT cycle; a flag in that cycle wins.
  assign timeout_hit = !bus.arith_flag && (wait_cnt_q == CNT_WD'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      wait_cnt_q <= '0;
    end else if ((state_q == ST_WAIT) && !bus.arith_flag) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = div0 ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (bus.arith_flag || timeout_hit) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    arith_en  = (state_q == ST_ISSUE);
    rsp_valid = (state_q == ST_RESP);
    busy      = (state_q != ST_IDLE);
    cmd_ready = (state_q == ST_IDLE) && !rst;
  end

  // Operand latches and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      arith_a_q   <= '0;
      arith_b_q   <= '0;
      arith_fun_q <= '0;
      rsp_data_q  <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      if (accept) begin
        arith_a_q   <= bus.cmd_a;
        arith_b_q   <= bus.cmd_b;
        arith_fun_q <= bus.cmd_fun;
        if (div0) begin
          rsp_data_q <= '0;
          rsp_err_q  <= ERR_DIV0;
        end
      end
      if (state_q == ST_WAIT) begin
        if (bus.arith_flag) begin
          rsp_data_q <= bus.arith_out;
          rsp_err_q  <= ERR_OK;
        end else if (timeout_hit) begin
          rsp_data_q <= '0;
          rsp_err_q  <= ERR_TIMEOUT;
        end
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.arith_a   = arith_a_q;
  assign bus.arith_b   = arith_b_q;
  assign bus.arith_fun = arith_fun_q;
  assign bus.arith_en  = arith_en;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_arith_cmd_issuer.sv
// tb/tb_arith_cmd_issuer.sv - self-checking bench for arith_cmd_issuer
// Ports: none. Honours ARITH_ISSUER_TIMEOUT_EN for the timeout scenarios.

module tb_arith_cmd_issuer;
  import arith_pkg::*;

  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arith_cmd_issuer_if #(.IN_DATA_WD(16), .OUT_WD(32)) bus ();

  arith_cmd_issuer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: transaction-level view of the issuer.
  int          n       = 0;
  bit          busy    = 1'b0;
  int          en_n    = -1;
  int          flag_n  = -1;
  int          rsp_from = 0;
  logic [31:0] exp_data = '0;
  logic [1:0]  exp_err  = '0;
  logic [31:0] flag_data = '0;
  logic [15:0] last_a   = '0;
  logic [15:0] last_b   = '0;
  logic [1:0]  last_fun = '0;
  int          next_d   = 1;
  bit          stray_en = 1'b0;
  bit          started  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [15:0] a, input logic [15:0] b,
                                             input logic [1:0] f);
    int ia, ib, r;
    ia = int'($signed(a));
    ib = int'($signed(b));
    case (f)
      2'b00:   r = ia + ib;
      2'b01:   r = ia - ib;
      2'b10:   r = ia * ib;
      default: r = ia / ib;
    endcase
    return r;
  endfunction

  task automatic model_update();
    n++;
    if (rst) begin
      busy = 1'b0; en_n = -1; flag_n = -1;
      last_a = '0; last_b = '0; last_fun = '0;
    end else if (!busy) begin
      if (bus.cmd_valid) begin
        busy = 1'b1;
        last_a = bus.cmd_a; last_b = bus.cmd_b; last_fun = bus.cmd_fun;
        if (bus.cmd_fun == 2'b11 && bus.cmd_b == 16'd0) begin
          en_n = -1; flag_n = -1; rsp_from = n; exp_data = '0; exp_err = 2'b01;
        end else begin
          en_n = n;
          flag_n = n + next_d;
          flag_data = ref_result(bus.cmd_a, bus.cmd_b, bus.cmd_fun);
          rsp_from = flag_n + 1; exp_data = flag_data; exp_err = 2'b00;
`ifdef ARITH_ISSUER_TIMEOUT_EN
          if (next_d > TO) begin
            rsp_from = n + 1 + TO; exp_data = '0; exp_err = 2'b10;
          end
`endif
        end
      end
    end else if ((n - 1) >= rsp_from && bus.rsp_ready) begin
      busy = 1'b0;
    end
  endtask

  // Arithmetic-unit stand-in: returns the scheduled result, plus optional stray flags
  // in cycles where the issuer must ignore them.
  task automatic drive_flag();
    bit ok;
    ok = !busy || (n == en_n) || (n >= rsp_from);
    if (busy && n == flag_n) begin
      bus.arith_flag = 1'b1; bus.arith_out = flag_data;
    end else if (stray_en && ok && $urandom_range(0, 3) == 0) begin
      bus.arith_flag = 1'b1; bus.arith_out = $urandom;
    end else begin
      bus.arith_flag = 1'b0; bus.arith_out = $urandom;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
    drive_flag();
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit ev;
    if (started) begin
      ev = busy && (n >= rsp_from);
      check("cmd_ready", {31'd0, bus.cmd_ready}, {31'd0, !busy && !rst});
      check("arith_en",  {31'd0, bus.arith_en},  {31'd0, busy && (n == en_n)});
      check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, ev});
      check("busy",      {31'd0, bus.busy},      {31'd0, busy});
      check("arith_a",   {16'd0, bus.arith_a},   {16'd0, last_a});
      check("arith_b",   {16'd0, bus.arith_b},   {16'd0, last_b});
      check("arith_fun", {30'd0, bus.arith_fun}, {30'd0, last_fun});
      if (ev) begin
        check("rsp_data", bus.rsp_data, exp_data);
        check("rsp_err",  {30'd0, bus.rsp_err}, {30'd0, exp_err});
      end
    end
  end

  task automatic run_cmd(input logic [15:0] a, input logic [15:0] b, input logic [1:0] f,
                         input int d, input int hold, input int exp_lat,
                         input logic [31:0] edata, input logic [1:0] eerr, input int exp_en);
    int k, lat, en_cnt;
    next_d = d;
    bus.cmd_valid = 1'b1; bus.cmd_a = a; bus.cmd_b = b; bus.cmd_fun = f;
    bus.rsp_ready = 1'b0;
    tick();
    k = n;
    bus.cmd_valid = 1'b0;
    en_cnt = 0;
    lat = -1;
    for (int i = 0; i < 40 && lat < 0; i++) begin
      if (bus.arith_en) en_cnt++;
      if (bus.rsp_valid) lat = n - k + 1;
      else tick();
    end
    check("latency", lat, exp_lat);
    check("en_pulses", en_cnt, exp_en);
    check("lit_data", bus.rsp_data, edata);
    check("lit_err", {30'd0, bus.rsp_err}, {30'd0, eerr});
    for (int i = 0; i < hold; i++) begin
      tick();
      check("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      check("hold_data", bus.rsp_data, edata);
      check("hold_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    end
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("ready_after_hs", {31'd0, bus.cmd_ready}, 32'd1);
  endtask

  initial begin
    int r;
    rst = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_a = '0; bus.cmd_b = '0; bus.cmd_fun = '0;
    bus.arith_flag = 1'b0; bus.arith_out = '0; bus.rsp_ready = 1'b0;

    check("pin_add", ref_result(16'd7, 16'd5, 2'b00), 32'h0000000C);
    check("pin_sub", ref_result(16'd3, 16'd10, 2'b01), 32'hFFFFFFF9);
    check("pin_mul", ref_result(16'hFED4, 16'd200, 2'b10), 32'hFFFF15A0);

    tick();
    started = 1'b1;
    tick();
    check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_err", {30'd0, bus.rsp_err}, 32'd0);
    check("rst_arith_en", {31'd0, bus.arith_en}, 32'd0);
    check("rst_arith_a", {16'd0, bus.arith_a}, 32'd0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

    run_cmd(16'd7, 16'd5, 2'b00, 1, 0, 3, 32'h0000000C, 2'b00, 1);
    run_cmd(16'd3, 16'd10, 2'b01, 1, 0, 3, 32'hFFFFFFF9, 2'b00, 1);
    run_cmd(16'hFED4, 16'd200, 2'b10, 1, 0, 3, 32'hFFFF15A0, 2'b00, 1);
    run_cmd(16'd100, 16'd0, 2'b11, 1, 0, 1, 32'd0, 2'b01, 0);
    run_cmd(16'd7, 16'd5, 2'b00, 1, 5, 3, 32'h0000000C, 2'b00, 1);
    run_cmd(16'd50, 16'd7, 2'b11, 4, 2, 6, 32'd7, 2'b00, 1);

    // Reset while waiting, then a stale flag in IDLE.
    next_d = 3;
    bus.cmd_valid = 1'b1; bus.cmd_a = 16'd1; bus.cmd_b = 16'd2; bus.cmd_fun = 2'b00;
    tick();
    bus.cmd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.arith_flag = 1'b1; bus.arith_out = 32'h1234;
    tick();
    tick();
    check("rstwait_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check("rstwait_busy", {31'd0, bus.busy}, 32'd0);
    check("rstwait_arith_a", {16'd0, bus.arith_a}, 32'd0);
    check("rstwait_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

`ifdef ARITH_ISSUER_TIMEOUT_EN
    run_cmd(16'd9, 16'd4, 2'b11, 20, 0, 17, 32'd0, 2'b10, 1);
    run_cmd(16'd9, 16'd4, 2'b11, 15, 0, 17, 32'd2, 2'b00, 1);
`endif

    stray_en = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      bus.cmd_valid = 1'($urandom_range(0, 1));
      bus.cmd_a = 16'($urandom);
      bus.cmd_b = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      bus.cmd_fun = 2'($urandom_range(0, 3));
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      rst = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 9);
      next_d = (r < 6) ? 1 : $urandom_range(2, 5);
`ifdef ARITH_ISSUER_TIMEOUT_EN
      if (r == 9) next_d = $urandom_range(13, 20);
`endif
      tick();
    end
    rst = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
